bcd_timer_core: RTL and testbench
=================================

# bcd_timer_core

Parametrised N-digit BCD stopwatch/countdown core with a keypad load path and a multiplexed seven-segment driver. It combines the counter, BCD conversion and display logic into one block. It sits between the keypad decoder (digit strobes) and the board's push-buttons/display, and replaces the fixed 4-digit counter/timer chain. Digit count, tick rate and scan rate are parameters.

## Interface
- DIGITS, 4: number of BCD digits (2..8)
- TICK_DIV, 50000000: clk cycles per count tick (≥2)
- SCAN_DIV, 50000: clk cycles per display digit slot (≥2)
- clk  in  1  system clock, all logic on rising edge
- reseta  in  1  asynchronous active-low reset
- sel  in  1  0 = count up (stopwatch), 1 = count down (timer)
- pause  in  1  active-low button (asynchronous); each falling edge toggles run/stop
- zero_n  in  1  active-low button (asynchronous); each falling edge clears count
- cfg  in  1  1 = configuration mode (keypad load enabled, ticking suppressed)
- key_valid  in  1  one-cycle strobe from keypad decoder
- key_digit  in  4  digit accompanying key_valid
- count  out  4*DIGITS  current value, BCD, digit 0 in [3:0]
- running  out  1  1 = counting enabled
- done  out  1  countdown reached zero
- seg  out  7  active-low segments, {g,f,e,d,c,b,a}
- an  out  DIGITS  active-low one-hot digit enable

## Operation
- pause and zero_n each pass through a 2-flop synchroniser plus a falling-edge detector. Each produces a 1-cycle internal event.
- Per-cycle update priority:
  1. zero event: count←0, done←0, running←0.
  2. cfg=1 and key_valid:
     - key_digit ≤ 9: count shifts left one digit, key_digit enters digit 0, MSD discarded, done←0.
     - key_digit > 9: ignored.
  3. pause event: running←~running. Ignored when sel=1 and count=0.
  4. tick, with running=1 and cfg=0:
     - sel=0: BCD increment with per-digit carry. All-max wraps to 0 and keeps running.
     - sel=1: BCD decrement with per-digit borrow. At the tick that produces 0: running←0, done←1.
- Prescaler counts 0..TICK_DIV-1. It holds at 0 while running=0 or cfg=1, so the first tick after start comes a full TICK_DIV cycles later.
- Display scanner: a SCAN_DIV prescaler advances digit index 0..DIGITS-1 with wrap. an has a low bit only at that index; seg shows the indexed digit decoded to 7-seg. Digit values >9 cannot occur.
- Changing sel mid-run: takes effect on the next tick; no other action.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert internally):
  - count=0, running=0, done=0
  - all prescalers 0, synchronisers at 1 (idle)
  - an=~1 (digit 0 enabled), seg=7'b1000000 ("0")
- Button latency: outputs change exactly 3 clk after the input falling edge (2 sync + edge register).
- Key load: count updates on the clk edge after key_valid is sampled high.
- Tick: count updates 1 clk after the prescaler reaches TICK_DIV-1.
- done rises in the same cycle count becomes 0 and running falls.
- Simultaneous events resolve strictly by the priority list above. Example: a zero event and a tick in the same cycle leave count=0.
- Reset mid-operation aborts any load or tick. No partial digit update is ever visible.
- Display: an/seg registered. Each digit is held SCAN_DIV cycles. A full frame is DIGITS*SCAN_DIV cycles.

## Configuration
- MODULO60_EN:
  - Defined, with DIGITS ≥ 2: digit 1 counts 0..5, giving an SS field (and MM:SS when DIGITS=4, with digit 3 a plain 0..9). Up-count 5→0 carries into digit 2. Down-count borrow loads digit1=5, digit0=9. A keypad load into digit 1 with value >5 is clamped to 5.
  - Undefined: all digits are plain decimal 0..9.

## Test plan
Parameters DIGITS=4, TICK_DIV=4, SCAN_DIV=2.
- Reset, pulse pause low 1 clk → running=1 at +3 clk; after 40 clk, count=16'h0010.
- cfg=1, strobes 1,2,3,4 → count=16'h1234. Strobe 4'hA → count unchanged. sel=1, cfg=0, pause → after 4 ticks count=16'h1230.
- Countdown from 16'h0002 → 16'h0001, then 16'h0000 with done=1 and running=0. A further pause event leaves running=0.
- Up-count from 16'h9999 (macro off) → 16'h0000, running stays 1. With MODULO60_EN: 16'h0059 → 16'h0100, and a down-count from 16'h0100 → 16'h0059.
- zero_n falling edge in the same cycle as a tick → count=0, running=0, done=0.
- With count=16'h1234, observe an sequence 1110,1101,1011,0111 (each 2 clk) and seg 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001. Assert reseta mid-scan → an=1110, seg=7'b1000000 immediately.

Source files
------------

// File: rtl/bcd_timer_core.sv
// bcd_timer_core: N-digit BCD stopwatch/countdown with keypad load and
// multiplexed seven-segment scan output.
// Optional feature macro: MODULO60_EN (digit 1 counts 0..5 for an SS field).
module bcd_timer_core #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reseta,
  input  logic                  sel,
  input  logic                  pause,
  input  logic                  zero_n,
  input  logic                  cfg,
  input  logic                  key_valid,
  input  logic [3:0]            key_digit,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(DIGITS);
`ifdef MODULO60_EN
  localparam logic [3:0] MAX1 = 4'd5;
`else
  localparam logic [3:0] MAX1 = 4'd9;
`endif

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [2:0]    pause_sh;
  logic [2:0]    zero_sh;
  logic          pause_evt;
  logic          zero_evt;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] cnt_dec;
  logic [CW-1:0] cnt_load;
  logic [CW-1:0] count_n;
  logic          running_n;
  logic          done_n;
  logic          carry;
  logic          borrow;
  logic [3:0]    lim;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic [3:0]    scan_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Reset synchroniser: asynchronous assert, clocked deassert
  always_ff @(posedge clk or negedge reseta) begin
    if (!reseta) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Button synchronisers plus falling-edge history register (idle high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_sh <= 3'b111;
      zero_sh  <= 3'b111;
    end else begin
      pause_sh <= {pause_sh[1:0], pause};
      zero_sh  <= {zero_sh[1:0], zero_n};
    end
  end
  assign pause_evt = pause_sh[2] & ~pause_sh[1];
  assign zero_evt  = zero_sh[2] & ~zero_sh[1];

  // Tick prescaler, parked at 0 whenever counting is not enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              tick_cnt <= '0;
    else if (!running || cfg)                tick_cnt <= '0;
    else if (tick_cnt == TW'(TICK_DIV - 1))  tick_cnt <= '0;
    else                                     tick_cnt <= tick_cnt + TW'(1);
  end
  assign tick = running & ~cfg & (tick_cnt == TW'(TICK_DIV - 1));

  // Candidate values: BCD increment, BCD decrement, keypad shift-in
  always_comb begin
    cnt_inc = count;
    cnt_dec = count;
    carry   = 1'b1;
    borrow  = 1'b1;
    lim     = 4'd9;
    for (int i = 0; i < int'(DIGITS); i++) begin
      lim = (i == 1) ? MAX1 : 4'd9;
      if (carry) begin
        if (count[4*i +: 4] >= lim) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          cnt_dec[4*i +: 4] = lim;
        end else begin
          cnt_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    cnt_load = {count[CW-5:0], key_digit};
`ifdef MODULO60_EN
    if (cnt_load[7:4] > 4'd5) cnt_load[7:4] = 4'd5;
`endif
  end

  // Next-state selection in strict priority: zero, load, pause, tick
  always_comb begin
    count_n   = count;
    running_n = running;
    done_n    = done;
    if (zero_evt) begin
      count_n   = '0;
      running_n = 1'b0;
      done_n    = 1'b0;
    end else if (cfg && key_valid && (key_digit <= 4'd9)) begin
      count_n = cnt_load;
      done_n  = 1'b0;
    end else if (pause_evt && !(sel && (count == '0))) begin
      running_n = ~running;
    end else if (tick) begin
      if (!sel) begin
        count_n = cnt_inc;
      end else begin
        count_n = cnt_dec;
        if (cnt_dec == '0) begin
          running_n = 1'b0;
          done_n    = 1'b1;
        end
      end
    end
  end

  // Counter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      count   <= count_n;
      running <= running_n;
      done    <= done_n;
    end
  end

  // Scan index advance and digit selection
  always_comb begin
    idx_n = idx;
    if (scan_cnt == SW'(SCAN_DIV - 1))
      idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    scan_digit = 4'(count >> {idx_n, 2'b00});
  end

  // Display scanner and registered segment/anode drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= ~DIGITS'(1);
      seg      <= 7'b1000000;
    end else begin
      scan_cnt <= (scan_cnt == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt + SW'(1);
      idx      <= idx_n;
      an       <= ~(DIGITS'(1) << idx_n);
      seg      <= seg_decode(scan_digit);
    end
  end

endmodule

// File: tb/tb_bcd_timer_core.sv
// Self-checking bench for bcd_timer_core (DIGITS=4, TICK_DIV=4, SCAN_DIV=2).
// Honors MODULO60_EN when defined for the build.
module tb_bcd_timer_core;
  localparam int D  = 4;
  localparam int TD = 4;
  localparam int SD = 2;

  logic            clk = 1'b0;
  logic            reseta = 1'b0;
  logic            sel = 1'b0;
  logic            pause = 1'b1;
  logic            zero_n = 1'b1;
  logic            cfg = 1'b0;
  logic            key_valid = 1'b0;
  logic [3:0]      key_digit = 4'd0;
  logic [4*D-1:0]  count;
  logic            running;
  logic            done;
  logic [6:0]      seg;
  logic [D-1:0]    an;

  int checks = 0;
  int errors = 0;

  // Reference model state: count held as a mixed-radix integer
  int         m_val;
  bit         m_run;
  bit         m_done;
  int         m_pc;
  logic [2:0] ph;
  logic [2:0] zh;
  logic [6:0] segtab [10];

  bcd_timer_core #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .reseta(reseta), .sel(sel), .pause(pause), .zero_n(zero_n),
    .cfg(cfg), .key_valid(key_valid), .key_digit(key_digit), .count(count),
    .running(running), .done(done), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  function automatic int rad(int i);
`ifdef MODULO60_EN
    return (i == 1) ? 6 : 10;
`else
    return 10;
`endif
  endfunction

  function automatic int max_val();
    int p = 1;
    for (int i = 0; i < D; i++) p = p * rad(i);
    return p;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(int v);
    logic [4*D-1:0] b = '0;
    for (int i = 0; i < D; i++) begin
      b[4*i +: 4] = 4'(v % rad(i));
      v = v / rad(i);
    end
    return b;
  endfunction

  function automatic int from_bcd(logic [4*D-1:0] b);
    int v = 0;
    int mul = 1;
    for (int i = 0; i < D; i++) begin
      v = v + int'(b[4*i +: 4]) * mul;
      mul = mul * rad(i);
    end
    return v;
  endfunction

  // One clock: advance DUT and the model with the inputs present at the edge
  task automatic cycle();
    bit pev, zev, tk;
    logic [4*D-1:0] b;
    @(posedge clk);
    pev = ph[2] && !ph[1];
    zev = zh[2] && !zh[1];
    ph  = {ph[1:0], pause};
    zh  = {zh[1:0], zero_n};
    tk  = m_run && !cfg && (m_pc == TD - 1);
    if (!m_run || cfg) m_pc = 0;
    else m_pc = (m_pc == TD - 1) ? 0 : m_pc + 1;
    if (zev) begin
      m_val = 0; m_run = 0; m_done = 0;
    end else if (cfg && key_valid && key_digit <= 4'd9) begin
      b = {to_bcd(m_val)[4*D-5:0], key_digit};
`ifdef MODULO60_EN
      if (b[7:4] > 4'd5) b[7:4] = 4'd5;
`endif
      m_val = from_bcd(b);
      m_done = 0;
    end else if (pev && !(sel && m_val == 0)) begin
      m_run = !m_run;
    end else if (tk) begin
      if (!sel) m_val = (m_val + 1) % max_val();
      else begin
        m_val = (m_val - 1 + max_val()) % max_val();
        if (m_val == 0) begin m_run = 0; m_done = 1; end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reseta = 1'b0; sel = 1'b0; pause = 1'b1; zero_n = 1'b1;
    cfg = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reseta = 1'b1;
    m_val = 0; m_run = 0; m_done = 0; m_pc = 0; ph = 3'b111; zh = 3'b111;
    repeat (3) cycle();
  endtask

  task automatic pulse_pause();
    pause = 1'b0; cycle(); pause = 1'b1;
  endtask

  task automatic pulse_zero();
    zero_n = 1'b0; cycle(); zero_n = 1'b1; cycle(); cycle();
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d; cycle(); key_valid = 1'b0;
  endtask

  task automatic toggle_run();
    pulse_pause(); cycle(); cycle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== '0 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%h running=%b done=%b required 0000/0/0", count, running, done);
    end
    checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_display: an=%b seg=%b required 1110/1000000", an, seg);
    end
  endtask

  task automatic test_start_count();
    pulse_pause(); cycle();
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL pause_latency_early: running=%b required 0", running);
    end
    cycle();
    checks++;
    if (running !== 1'b1 || running !== m_run) begin
      errors++; $display("FAIL pause_latency: running=%b required 1", running);
    end
    repeat (40) cycle();
    checks++;
    if (count !== 16'h0010 || count !== to_bcd(m_val)) begin
      errors++; $display("FAIL upcount_40clk: count=%h required 0010", count);
    end
    toggle_run();
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL pause_stop: running=%b required 0", running);
    end
  endtask

  task automatic test_key_load();
    pulse_zero();
    cfg = 1'b1;
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    checks++;
    if (count !== 16'h1234) begin
      errors++; $display("FAIL key_load: count=%h required 1234", count);
    end
    key(4'hA);
    checks++;
    if (count !== 16'h1234) begin
      errors++; $display("FAIL key_invalid: count=%h required 1234", count);
    end
    cfg = 1'b0; sel = 1'b1;
    toggle_run();
    repeat (16) cycle();
    checks++;
    if (count !== 16'h1230 || count !== to_bcd(m_val)) begin
      errors++; $display("FAIL countdown_4ticks: count=%h required 1230", count);
    end
    toggle_run();
  endtask

  task automatic test_countdown_done();
    pulse_zero();
    cfg = 1'b1; key(4'd2); cfg = 1'b0; sel = 1'b1;
    toggle_run();
    repeat (4) cycle();
    checks++;
    if (count !== 16'h0001 || running !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL countdown_one: count=%h run=%b done=%b required 0001/1/0", count, running, done);
    end
    repeat (4) cycle();
    checks++;
    if (count !== 16'h0000 || running !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL countdown_zero: count=%h run=%b done=%b required 0000/0/1", count, running, done);
    end
    toggle_run();
    checks++;
    if (running !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL pause_at_zero: run=%b done=%b required 0/1", running, done);
    end
  endtask

  task automatic test_wrap();
    pulse_zero();
    sel = 1'b0;
`ifndef MODULO60_EN
    cfg = 1'b1; key(4'd9); key(4'd9); key(4'd9); key(4'd9); cfg = 1'b0;
    toggle_run();
    repeat (4) cycle();
    checks++;
    if (count !== 16'h0000 || running !== 1'b1) begin
      errors++; $display("FAIL up_wrap: count=%h run=%b required 0000/1", count, running);
    end
    toggle_run();
`else
    cfg = 1'b1; key(4'd5); key(4'd9); cfg = 1'b0;
    toggle_run();
    repeat (4) cycle();
    checks++;
    if (count !== 16'h0100) begin
      errors++; $display("FAIL mod60_up: count=%h required 0100", count);
    end
    toggle_run();
    sel = 1'b1;
    toggle_run();
    repeat (4) cycle();
    checks++;
    if (count !== 16'h0059) begin
      errors++; $display("FAIL mod60_down: count=%h required 0059", count);
    end
    toggle_run();
    pulse_zero();
    cfg = 1'b1; key(4'd7); key(4'd7); cfg = 1'b0;
    checks++;
    if (count !== 16'h0057) begin
      errors++; $display("FAIL mod60_clamp: count=%h required 0057", count);
    end
`endif
    checks++;
    if (count !== to_bcd(m_val) || running !== m_run) begin
      errors++; $display("FAIL wrap_model: count=%h run=%b required %h/%b", count, running, to_bcd(m_val), m_run);
    end
  endtask

  task automatic test_zero_tick();
    pulse_zero();
    cfg = 1'b1; key(4'd5); cfg = 1'b0; sel = 1'b0;
    toggle_run();
    cycle();
    zero_n = 1'b0; cycle(); zero_n = 1'b1; cycle();
    checks++;
    if (count !== 16'h0005 || running !== 1'b1) begin
      errors++; $display("FAIL zero_tick_pre: count=%h run=%b required 0005/1", count, running);
    end
    cycle();
    checks++;
    if (count !== 16'h0000 || running !== 1'b0 || done !== 1'b0 || count !== to_bcd(m_val)) begin
      errors++; $display("FAIL zero_tick: count=%h run=%b done=%b required 0000/0/0", count, running, done);
    end
  endtask

  task automatic test_display();
    logic [D-1:0] prev_an;
    logic [D-1:0] exp_an;
    logic [4*D-1:0] b;
    bit aligned = 0;
    pulse_zero();
    cfg = 1'b1; key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    prev_an = an;
    for (int t = 0; t < 40 && !aligned; t++) begin
      cycle();
      if (prev_an === 4'b0111 && an === 4'b1110) aligned = 1;
      prev_an = an;
    end
    checks++;
    if (!aligned) begin
      errors++; $display("FAIL scan_align: an=%b required 0111->1110 transition", an);
    end
    b = to_bcd(m_val);
    for (int k = 0; k < 2 * D * SD; k++) begin
      exp_an = ~(D'(1) << ((k / SD) % D));
      checks++;
      if (an !== exp_an || seg !== segtab[b[4*((k/SD)%D) +: 4]]) begin
        errors++; $display("FAIL scan_k%0d: an=%b seg=%b required %b/%b", k, an, seg, exp_an, segtab[b[4*((k/SD)%D) +: 4]]);
      end
      cycle();
    end
    aligned = 0;
    for (int t = 0; t < 20 && !aligned; t++) begin
      if (an === 4'b1011) aligned = 1;
      else cycle();
    end
    reseta = 1'b0;
    #1;
    checks++;
    if (!aligned || an !== 4'b1110 || seg !== 7'b1000000 || count !== '0) begin
      errors++; $display("FAIL reset_mid_scan: an=%b seg=%b count=%h required 1110/1000000/0000", an, seg, count);
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      pause  = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
      zero_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 99) == 0) cfg = ~cfg;
      if ($urandom_range(0, 149) == 0) sel = ~sel;
      key_valid = cfg && ($urandom_range(0, 2) == 0);
      key_digit = 4'($urandom_range(0, 15));
      cycle();
      checks++;
      if (count !== to_bcd(m_val) || running !== m_run || done !== m_done) begin
        errors++;
        $display("FAIL random_t%0d: count=%h run=%b done=%b required %h/%b/%b", t, count, running, done, to_bcd(m_val), m_run, m_done);
      end
    end
    pause = 1'b1; zero_n = 1'b1; key_valid = 1'b0;
  endtask

  initial begin
    segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
    segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
    segtab[9] = 7'b0010000;
    test_reset();
    test_start_count();
    test_key_load();
    test_countdown_done();
    test_wrap();
    test_zero_tick();
    test_display();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
